// File: rtl/calc_sequencer_if.sv
// Key-input, ALU start/done and display bundle of the calculator sequencer.
// master is the sequencer side; slave is the keyboard/ALU/VGA side.
interface calc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             key_valid;
  logic [3:0]       key_code;
  logic             key_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic             alu_start;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] disp_value;
  logic             entry_ovf;
  logic             err;

  modport master (
    input  key_valid, key_code, alu_done, alu_result,
    output key_ready, alu_a, alu_b, alu_op, alu_start, disp_value, entry_ovf, err
  );

  modport slave (
    output key_valid, key_code, alu_done, alu_result,
    input  key_ready, alu_a, alu_b, alu_op, alu_start, disp_value, entry_ovf, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keystroke-driven calculator controller: builds decimal operands, launches ALU
// operations over a start/done handshake, chains results and drives the display.
module calc_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  calc_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    EXEC,
    WAIT,
    SHOW,
    ERR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [1:0]       pend_op;
  logic             b_entered;
  logic             chain;
  logic [CNT_W-1:0] cnt;

  logic             key_fire;
  logic             is_digit;
  logic             is_op;
  logic             is_eq;
  logic             is_clr;
  logic [3:0]       op_code;
  logic [1:0]       key_op;
  logic [WIDTH+3:0] acc_sel;
  logic [WIDTH+3:0] acc_next;
  logic             acc_ok;

  assign key_fire = bus.key_valid && bus.key_ready;
  assign is_digit = (bus.key_code <= 4'd9);
  assign is_op    = (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
  assign is_eq    = (bus.key_code == 4'd14);
  assign is_clr   = (bus.key_code == 4'd15);
  assign op_code  = bus.key_code - 4'd10;
  assign key_op   = op_code[1:0];

  // Widened by 4 bits so acc*10+9 never wraps before the range check.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_sel  = {4'b0, a};
    if (state == ENTER_B) acc_sel = {4'b0, b};
    acc_next = acc_sel * (WIDTH+4)'(10) + (WIDTH+4)'(bus.key_code);
    acc_ok   = (acc_next <= {4'b0, {WIDTH{1'b1}}});
  end

  // NOTE: all state and registered outputs use <= so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ENTER_A;
      a              <= '0;
      b              <= '0;
      op             <= '0;
      pend_op        <= '0;
      b_entered      <= 1'b0;
      chain          <= 1'b0;
      cnt            <= '0;
      bus.key_ready  <= 1'b1;
      bus.alu_start  <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.disp_value <= '0;
      bus.entry_ovf  <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.alu_start <= 1'b0;
      // key_ready is low in EXEC/WAIT, so a clear can only land in the other states.
      if (key_fire && is_clr) begin
        state          <= ENTER_A;
        a              <= '0;
        b              <= '0;
        op             <= '0;
        b_entered      <= 1'b0;
        bus.entry_ovf  <= 1'b0;
        bus.err        <= 1'b0;
        bus.disp_value <= '0;
      end else begin
        case (state)
          ENTER_A: begin
            if (key_fire && is_digit) begin
              if (acc_ok) begin
                a              <= acc_next[WIDTH-1:0];
                bus.disp_value <= acc_next[WIDTH-1:0];
              end else begin
                bus.entry_ovf <= 1'b1;
              end
            end else if (key_fire && is_op) begin
              op        <= key_op;
              b         <= '0;
              b_entered <= 1'b0;
              state     <= ENTER_B;
            end
          end

          ENTER_B: begin
            if (key_fire && is_digit) begin
              if (acc_ok) begin
                b              <= acc_next[WIDTH-1:0];
                b_entered      <= 1'b1;
                bus.disp_value <= acc_next[WIDTH-1:0];
              end else begin
                bus.entry_ovf <= 1'b1;
              end
            end else if (key_fire && is_op && !b_entered) begin
              op <= key_op;
            end else if (key_fire && (is_op || is_eq) && b_entered) begin
              // An operator here both executes the old op and queues itself as the next one.
              state          <= EXEC;
              bus.alu_start  <= 1'b1;
              bus.alu_a      <= a;
              bus.alu_b      <= b;
              bus.alu_op     <= op;
              bus.key_ready  <= 1'b0;
              bus.disp_value <= a;
              b              <= '0;
              b_entered      <= 1'b0;
              chain          <= is_op;
              if (is_op) pend_op <= key_op;
            end
          end

          EXEC: begin
            state <= WAIT;
            cnt   <= '0;
          end

          WAIT: begin
            if (bus.alu_done) begin
              a              <= bus.alu_result;
              bus.disp_value <= bus.alu_result;
              bus.key_ready  <= 1'b1;
              if (chain) begin
                op    <= pend_op;
                state <= ENTER_B;
              end else begin
                state <= SHOW;
              end
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
              state          <= ERR;
              bus.err        <= 1'b1;
              bus.disp_value <= '0;
              bus.key_ready  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          SHOW: begin
            if (key_fire && is_digit) begin
              a              <= WIDTH'(bus.key_code);
              bus.disp_value <= WIDTH'(bus.key_code);
              bus.entry_ovf  <= 1'b0;
              state          <= ENTER_A;
            end else if (key_fire && is_op) begin
              op        <= key_op;
              b         <= '0;
              b_entered <= 1'b0;
              state     <= ENTER_B;
            end
          end

          ERR: ;

          default: state <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: expected ALU launches are queued by the
// stimulus thread and compared by an independent monitor on every alu_start.
module tb_calc_sequencer;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 255;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_AND = 4'd12;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } issue_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic             resp_done   = 1'b0;
  logic             stray_done  = 1'b0;
  logic [WIDTH-1:0] resp_result = '0;
  int               alu_lat     = 1;
  int               last_wait   = 0;

  int checks = 0;
  int errors = 0;

  issue_t exp_q[$];

  calc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  assign bus.alu_done   = resp_done | stray_done;
  assign bus.alu_result = resp_result;

  calc_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
    issue_t e;
    e.a = a; e.b = b; e.op = op;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_key(input logic [3:0] code);
    int n = 0;
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    while (!bus.key_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL key_accept_timeout: key %0d not accepted after %0d cycles", code, n);
    end
    last_wait = n;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.key_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL ready_timeout: key_ready still low after %0d cycles", n);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic [1:0] op);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  // ALU responder: done arrives alu_lat cycles after the start cycle; negative means never.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.alu_start && alu_lat > 0) begin
        repeat (alu_lat) @(negedge clk);
        resp_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
        resp_done   = 1'b1;
        @(negedge clk);
        resp_done   = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the next queued expectation and last one cycle.
  initial begin
    logic   prev_start;
    issue_t e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.alu_start) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: a=%0d b=%0d op=%0d", bus.alu_a, bus.alu_b, bus.alu_op);
        end else begin
          e = exp_q.pop_front();
          check("alu_a", 32'(bus.alu_a), 32'(e.a));
          check("alu_b", 32'(bus.alu_b), 32'(e.b));
          check("alu_op", 32'(bus.alu_op), 32'(e.op));
        end
        check("alu_start_one_cycle", 32'(prev_start), 0);
      end
      prev_start = bus.alu_start;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key_ready", 32'(bus.key_ready), 1);
    check("rst_alu_start", 32'(bus.alu_start), 0);
    check("rst_alu_a", 32'(bus.alu_a), 0);
    check("rst_alu_b", 32'(bus.alu_b), 0);
    check("rst_alu_op", 32'(bus.alu_op), 0);
    check("rst_disp", 32'(bus.disp_value), 0);
    check("rst_entry_ovf", 32'(bus.entry_ovf), 0);
    check("rst_err", 32'(bus.err), 0);
    rst = 1'b0;

    // 12 + 34 with a one-cycle ALU
    alu_lat = 1;
    send_key(4'd1);  check("t1_disp_1", 32'(bus.disp_value), 1);
    send_key(4'd2);  check("t1_disp_12", 32'(bus.disp_value), 12);
    send_key(K_ADD); check("t1_disp_op", 32'(bus.disp_value), 12);
    send_key(4'd3);  check("t1_disp_3", 32'(bus.disp_value), 3);
    send_key(4'd4);  check("t1_disp_34", 32'(bus.disp_value), 34);
    push_exp(16'd12, 16'd34, 2'd0);
    send_key(K_EQ);
    check("t1_exec_start", 32'(bus.alu_start), 1);
    check("t1_exec_ready", 32'(bus.key_ready), 0);
    @(negedge clk);
    check("t1_wait_start", 32'(bus.alu_start), 0);
    check("t1_wait_ready", 32'(bus.key_ready), 0);
    @(negedge clk);
    check("t1_show_ready", 32'(bus.key_ready), 1);
    check("t1_show_disp", 32'(bus.disp_value), 46);

    // chain 5 - 2 + 1 =
    send_key(4'd5);  check("t2_disp_5", 32'(bus.disp_value), 5);
    send_key(K_SUB); check("t2_disp_op", 32'(bus.disp_value), 5);
    send_key(4'd2);  check("t2_disp_2", 32'(bus.disp_value), 2);
    push_exp(16'd5, 16'd2, 2'd1);
    send_key(K_ADD);
    check("t2_chain_ready", 32'(bus.key_ready), 0);
    wait_ready();
    check("t2_chain_disp", 32'(bus.disp_value), 3);
    send_key(4'd1);  check("t2_disp_1", 32'(bus.disp_value), 1);
    push_exp(16'd3, 16'd1, 2'd0);
    send_key(K_EQ);
    wait_ready();
    check("t2_final_disp", 32'(bus.disp_value), 4);

    // operator replaced twice without a digit; subtraction wraps
    send_key(K_ADD); check("t3_no_start_1", 32'(bus.alu_start), 0);
    send_key(K_SUB); check("t3_no_start_2", 32'(bus.alu_start), 0);
    check("t3_disp_a", 32'(bus.disp_value), 4);
    send_key(4'd9);
    push_exp(16'd4, 16'd9, 2'd1);
    send_key(K_EQ);
    wait_ready();
    check("t3_wrap_disp", 32'(bus.disp_value), 65531);

    // entry overflow
    send_key(K_CLR); check("t4_clr_disp", 32'(bus.disp_value), 0);
    send_key(4'd6); send_key(4'd5); send_key(4'd5); send_key(4'd3);
    check("t4_disp_6553", 32'(bus.disp_value), 6553);
    check("t4_ovf_clear", 32'(bus.entry_ovf), 0);
    send_key(4'd6);
    check("t4_disp_kept", 32'(bus.disp_value), 6553);
    check("t4_ovf_set", 32'(bus.entry_ovf), 1);
    send_key(4'd9);
    check("t4_disp_kept2", 32'(bus.disp_value), 6553);
    send_key(K_CLR);
    check("t4_clr_disp2", 32'(bus.disp_value), 0);
    check("t4_clr_ovf", 32'(bus.entry_ovf), 0);

    // ALU timeout
    alu_lat = -1;
    send_key(4'd1); send_key(K_ADD); send_key(4'd2);
    push_exp(16'd1, 16'd2, 2'd0);
    send_key(K_EQ);
    repeat (TIMEOUT) @(negedge clk);
    check("t5_last_wait_err", 32'(bus.err), 0);
    check("t5_last_wait_ready", 32'(bus.key_ready), 0);
    @(negedge clk);
    check("t5_err", 32'(bus.err), 1);
    check("t5_err_disp", 32'(bus.disp_value), 0);
    check("t5_err_ready", 32'(bus.key_ready), 1);
    send_key(4'd5);
    check("t5_digit_ignored", 32'(bus.disp_value), 0);
    check("t5_err_held", 32'(bus.err), 1);
    send_key(K_CLR);
    check("t5_clr_err", 32'(bus.err), 0);
    send_key(4'd3);
    check("t5_enter_a", 32'(bus.disp_value), 3);

    // slow ALU while digit 7 is held
    send_key(K_CLR);
    send_key(4'd8); send_key(K_AND); send_key(4'd1); send_key(4'd2);
    check("t6_disp_12", 32'(bus.disp_value), 12);
    alu_lat = 10;
    push_exp(16'd8, 16'd12, 2'd2);
    send_key(K_EQ);
    send_key(4'd7);
    check("t6_held_cycles", 32'(last_wait), 11);
    check("t6_new_a", 32'(bus.disp_value), 7);
    check("t6_ovf", 32'(bus.entry_ovf), 0);
    alu_lat = 1;
    send_key(K_ADD); send_key(4'd1);
    push_exp(16'd7, 16'd1, 2'd0);
    send_key(K_EQ);
    wait_ready();
    check("t6_sum", 32'(bus.disp_value), 8);

    // reset during WAIT, then a stray done
    alu_lat = -1;
    send_key(4'd2); send_key(K_ADD); send_key(4'd3);
    push_exp(16'd2, 16'd3, 2'd0);
    send_key(K_EQ);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_ready", 32'(bus.key_ready), 1);
    check("t7_alu_a", 32'(bus.alu_a), 0);
    check("t7_alu_b", 32'(bus.alu_b), 0);
    check("t7_disp", 32'(bus.disp_value), 0);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("t7_stray_disp", 32'(bus.disp_value), 0);
    check("t7_stray_ready", 32'(bus.key_ready), 1);
    check("t7_stray_err", 32'(bus.err), 0);
    send_key(K_EQ);
    check("t7_eq_ignored", 32'(bus.disp_value), 0);
    alu_lat = 1;
    send_key(K_ADD); send_key(4'd4);
    push_exp(16'd0, 16'd4, 2'd0);
    send_key(K_EQ);
    wait_ready();
    check("t7_a_zero_sum", 32'(bus.disp_value), 4);

    // rst and key_valid in the same cycle
    send_key(4'd9);
    check("t8_disp_9", 32'(bus.disp_value), 9);
    rst = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    bus.key_valid = 1'b0;
    check("t8_key_dropped", 32'(bus.disp_value), 0);
    @(negedge clk);
    check("t8_still_zero", 32'(bus.disp_value), 0);

    repeat (3) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keystroke-driven controller that sequences the calculator ALU inside the processor datapath. It accepts decoded key codes from the keyboard path of the I/O interface and builds decimal operands A and B. It issues each operation to the ALU over a start/done handshake, chains results into the next operation, and drives the value the VGA path displays.

## Interface
- WIDTH, 16, operand/result width in bits
- TIMEOUT, 255, max cycles from alu_start to alu_done before error
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- key_valid  in  1  key_code valid; accepted when key_valid && key_ready
- key_code  in  4  0–9 digit, 10 add, 11 sub, 12 and, 13 or, 14 '=', 15 'C' (clear)
- key_ready  out  1  controller can accept a key
- alu_a, alu_b  out  WIDTH  operands, stable from alu_start until alu_done
- alu_op  out  2  0 add, 1 sub, 2 and, 3 or (key_code − 10)
- alu_start  out  1  one-cycle pulse launching an operation
- alu_done  in  1  one-cycle pulse; alu_result valid in that cycle
- alu_result  in  WIDTH  ALU result
- disp_value  out  WIDTH  value to display
- entry_ovf  out  1  sticky: a digit was rejected for overflow
- err  out  1  ALU timeout; cleared only by 'C' or rst

## Operation
- States: ENTER_A, ENTER_B, EXEC, WAIT, SHOW, ERR. Registers a, b, op, b_entered, timeout counter.
- Digit accumulation: next = acc*10 + d, computed at WIDTH+4 bits. If next > 2^WIDTH−1, reject the digit, leave acc unchanged and set entry_ovf.
- ENTER_A:
  - digit → a accumulates.
  - operator → latch op, b=0, b_entered=0, go to ENTER_B.
  - '=' → ignored.
- ENTER_B:
  - digit → b accumulates, b_entered=1.
  - operator with b_entered=0 → replace op only.
  - operator with b_entered=1 → EXEC with the old op; the new op is held as pending and becomes op after the result returns. Return to ENTER_B with b=0, b_entered=0.
  - '=' with b_entered=1 → EXEC, then SHOW.
  - '=' with b_entered=0 → ignored.
- EXEC: alu_start=1 for exactly one cycle with alu_a=a, alu_b=b, alu_op=op. Go to WAIT.
- WAIT:
  - alu_done → a=alu_result; go to SHOW, or to ENTER_B if chained.
  - TIMEOUT cycles elapse without alu_done → ERR.
- SHOW:
  - digit → a=d, entry_ovf=0, go to ENTER_A.
  - operator → latch op, b=0, go to ENTER_B.
  - '=' → ignored.
- ERR: all keys except 'C' are ignored.
- 'C' in any state except EXEC/WAIT: a=b=0, op=0, entry_ovf=0, err=0, go to ENTER_A.
- key_ready=0 in EXEC and WAIT; 1 otherwise. Keys are never dropped silently, because the source must hold key_valid until accepted.
- disp_value:
  - ENTER_A: a.
  - ENTER_B: b if b_entered, else a.
  - EXEC/WAIT: a.
  - SHOW: a.
  - ERR: 0.
- Arithmetic wrap/overflow inside the ALU is not checked here; the result is taken as-is, mod 2^WIDTH.

## Timing
- Reset values: state ENTER_A, a=b=0, op=0, key_ready=1, alu_start=0, alu_a=alu_b=0, alu_op=0, disp_value=0, entry_ovf=0, err=0.
- Key accepted in cycle N → registers and disp_value updated at N+1.
- Execute ('=' or chaining operator) accepted in cycle N:
  - alu_start high in N+1.
  - WAIT from N+2.
  - key_ready low in N+1 through the cycle of alu_done.
- alu_done in cycle M → a and disp_value updated at M+1; key_ready=1 at M+1.
- Fastest ALU: alu_done is legal no earlier than N+2, the first WAIT cycle.
- Timeout counter starts at 0 in N+2. ERR is entered when the count reaches TIMEOUT without alu_done.
- alu_done in the same cycle as timeout expiry: done wins.
- alu_done outside WAIT is ignored.
- rst asserted mid-WAIT: reset values apply next cycle. A later stray alu_done is ignored.
- key_valid and rst in the same cycle: rst wins and the key is not accepted.

## Test plan
- Keys 1,2,+,3,4,= with a 1-cycle ALU returning a+b → alu_a=12, alu_b=34, alu_op=0, alu_start one cycle; disp_value=46 in SHOW; key_ready low only for the EXEC/WAIT cycles.
- Chain 5,−,2,+,1,= → first op is 5−2, then 3+1; final disp_value=4. Operator pressed twice (+,−) with no digit → only op changes, no alu_start.
- Entry overflow, 6,5,5,3,6 then 9 → a=65536 rejected at the last digit, disp_value stays 6553, entry_ovf=1. 'C' → disp_value=0, entry_ovf=0.
- ALU never asserts alu_done, TIMEOUT=255 → ERR exactly 255 cycles after WAIT entry; err=1, disp_value=0; digits ignored; 'C' → ENTER_A, err=0.
- ALU delays done by 10 cycles while key_valid is held high with digit 7 → key not accepted until done+1. Then SHOW accepts 7 as the new A: disp_value=7, state ENTER_A.
- rst pulsed during WAIT, then a stray alu_done → all outputs at reset values, a stays 0, no state change.
